mining_core_dispatch: RTL
=========================

Name: mining_core_dispatch

Overview:
Nonce-space dispatcher and result collector between uart_ctrl and CORE_NUM parallel double_sha256_calc cores. On a new job it splits the 32-bit nonce space into CORE_NUM equal slices and broadcasts job data to every core. It starts each core with its slice base, then arbitrates found nonces round-robin into a result FIFO. After all cores exhaust their slices and the FIFO has drained, it reports one "nonce space full" beat back to uart_ctrl. It generalises the single-core hookup to N cores, adds output back-pressure, and adds job abort.

Parameters:
CORE_NUM, 4, number of hash cores; power of 2, range 1..16
CORE_IDX_WID, 2, log2(CORE_NUM); 0 is allowed when CORE_NUM=1
MINING_DATA_WID, 608, mining header data width
TARGET_WID, 256, target width
DATA_WID, 32, word / nonce / extranounce2 width
FIFO_DEPTH, 8, result FIFO entries; power of 2, ≥2

Ports:
clk  in  1  module clock
rst  in  1  synchronous reset, active-high
i_mining_en  in  1  job enable from uart_ctrl; a rising edge starts a job
iv_mining_data  in  MINING_DATA_WID  job header data
iv_mining_target  in  TARGET_WID  job target
iv_mining_extranounce2  in  DATA_WID  job extranounce2
o_core_start  out  CORE_NUM  per-core one-cycle start pulse
o_core_abort  out  1  one-cycle abort pulse broadcast to all cores
ov_core_data  out  MINING_DATA_WID  registered job data, broadcast to all cores
ov_core_target  out  TARGET_WID  registered target, broadcast to all cores
ov_core_nonce_base  out  CORE_NUM*DATA_WID  per-core slice base; core i occupies bits [i*DATA_WID +: DATA_WID]
iv_core_nonce  in  CORE_NUM*DATA_WID  per-core found nonce
i_core_nonce_vld  in  CORE_NUM  core holds its nonce valid until acked
o_core_nonce_ack  out  CORE_NUM  one-hot grant; a transfer occurs when vld & ack
i_core_done  in  CORE_NUM  one-cycle pulse when a core's slice is exhausted
ov_mining_extranounce2  out  DATA_WID  extranounce2 of the current result
ov_mining_nounce  out  DATA_WID  result nonce
o_mining_nounce_vld  out  1  result valid; held until accepted
o_mining_nounce_full  out  1  qualifies the vld beat as the space-full marker
i_mining_nounce_rdy  in  1  uart side accepts the result when vld & rdy
o_overflow  out  1  sticky flag: a result was lost; cleared by rst or a new job start

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, the FIFO is empty, and the done mask is cleared.
- Job start: a rising edge of i_mining_en, detected from a registered copy.
  - The block latches data, target and extranounce2.
  - ov_core_nonce_base[i] = i << (DATA_WID - CORE_IDX_WID), so each slice spans 2^(DATA_WID-CORE_IDX_WID) nonces.
- FSM states: IDLE, LOAD, RUN, DRAIN, FULL.
  - IDLE -> LOAD on a start edge. LOAD lasts 1 cycle and registers the outputs. Then o_core_start = all-ones for 1 cycle and the FSM goes to RUN. Start latency from the edge to o_core_start is 2 cycles.
  - RUN: done pulses OR into done_mask. When done_mask is all-ones, the FSM goes to DRAIN.
  - DRAIN: the arbiter keeps servicing any pending vld. When no vld is pending and the FIFO is empty, the FSM goes to FULL.
  - FULL: drives vld=1, full=1, nounce=0xFFFFFFFF and the latched extranounce2. When accepted (vld & rdy), the FSM goes to IDLE.
- Start edge while in RUN, DRAIN or FULL:
  - o_core_abort pulses.
  - FIFO and done_mask flush in the same cycle.
  - A pending output beat is withdrawn.
  - The FSM then goes to LOAD with the new job. No result from the old job may appear after the abort cycle.
- Arbiter: round-robin over i_core_nonce_vld. At most one ack per cycle, and ack is combinational on the registered pointer. The pointer advances to grant+1 after a transfer.
  - Grant only while the FIFO is not full.
  - Exception: if the FIFO is full and rdy is 0 for 16 consecutive cycles, the granted nonce is acked and dropped, and o_overflow is set. This prevents deadlock.
- FIFO: each entry holds {extranounce2, nonce}.
  - Write and read in the same cycle when full is allowed; occupancy stays unchanged.
  - Show-ahead output: vld = !empty outside FULL, and data is valid in the same cycle as vld.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- Nonce pulses and done pulses from the same core in the same cycle are both honoured. The nonce is queued before the FULL beat.
- i_mining_en falling edge: no effect.
- rst mid-job: returns to the reset state. Cores are not aborted by this block; cores share the same rst.

Decomposition:
- Shared package mining_pkg: DATA_WID, MINING_DATA_WID, TARGET_WID, and the FSM state encoding (3-bit localparams). Also the constant FULL_MARKER_NONCE = 32'hFFFF_FFFF.
- Sub-module mining_result_fifo: synchronous show-ahead FIFO with parameters WIDTH and DEPTH, ports wr/rd/full/empty/flush.
- The arbiter stays inline.

Test Plan:
- CORE_NUM=4, start edge -> o_core_start=4'b1111 exactly 2 cycles later; bases 0x00000000 / 0x40000000 / 0x80000000 / 0xC0000000.
- Cores 1, 2 and 3 raise vld in the same cycle with 0x4000_0010, 0x8000_0020, 0xC000_0030; rdy=1 -> three acks on consecutive cycles; outputs in order 0x40000010, 0x80000020, 0xC0000030, each with extranounce2=0x12345678.
- rdy=0, cores push 9 nonces with FIFO_DEPTH=8 -> 8 are stored, the 9th is held un-acked for 16 cycles, then dropped with o_overflow=1. Raising rdy then yields the 8 in order.
- All four i_core_done pulses in different cycles, one nonce still pending -> the nonce beat is emitted first, then a beat with full=1 and nounce=0xFFFFFFFF; the FSM returns to IDLE.
- New start edge in RUN with 3 FIFO entries pending -> o_core_abort pulses, vld drops the next cycle, no old nonce is emitted, and a new o_core_start follows 2 cycles after the edge.
- CORE_NUM=1 build -> base 0x00000000; full is reported after a single done pulse.

Source files
------------

// File: rtl/mining_pkg.sv
// Shared widths, FSM state encoding and marker constants for the mining dispatcher.
package mining_pkg;

   localparam int DATA_WID        = 32;
   localparam int MINING_DATA_WID = 608;
   localparam int TARGET_WID      = 256;

   localparam logic [31:0] FULL_MARKER_NONCE = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_FULL  = 3'd4
   } dispatchState_t;

endpackage

// File: rtl/mining_result_fifo.sv
// Synchronous show-ahead FIFO holding found results; the head word is valid whenever not empty.
module mining_result_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic             i_wr,
   input  logic [WIDTH-1:0] iv_wrData,
   input  logic             i_rd,
   output logic [WIDTH-1:0] ov_rdData,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wrPtr;
   logic [AW:0]      r_rdPtr;
   logic             w_wrEn;
   logic             w_rdEn;

   // The extra pointer bit separates full from empty when the index bits match.
   assign o_empty   = (r_wrPtr == r_rdPtr);
   assign o_full    = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
   assign w_rdEn    = i_rd && !o_empty;
   assign w_wrEn    = i_wr && (!o_full || w_rdEn);
   assign ov_rdData = r_mem[r_rdPtr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_wrEn) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_rdEn) r_rdPtr <= r_rdPtr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wrEn) r_mem[r_wrPtr[AW-1:0]] <= iv_wrData;
   end

endmodule

// File: rtl/mining_core_dispatch.sv
// Splits the nonce space across CORE_NUM hash cores, collects found nonces round-robin
// into a result FIFO and reports a single space-full beat once every core is done.
module mining_core_dispatch #(
   parameter int CORE_NUM        = 4,
   parameter int CORE_IDX_WID    = 2,
   parameter int MINING_DATA_WID = mining_pkg::MINING_DATA_WID,
   parameter int TARGET_WID      = mining_pkg::TARGET_WID,
   parameter int DATA_WID        = mining_pkg::DATA_WID,
   parameter int FIFO_DEPTH      = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_mining_en,
   input  logic [MINING_DATA_WID-1:0]   iv_mining_data,
   input  logic [TARGET_WID-1:0]        iv_mining_target,
   input  logic [DATA_WID-1:0]          iv_mining_extranounce2,
   output logic [CORE_NUM-1:0]          o_core_start,
   output logic                         o_core_abort,
   output logic [MINING_DATA_WID-1:0]   ov_core_data,
   output logic [TARGET_WID-1:0]        ov_core_target,
   output logic [CORE_NUM*DATA_WID-1:0] ov_core_nonce_base,
   input  logic [CORE_NUM*DATA_WID-1:0] iv_core_nonce,
   input  logic [CORE_NUM-1:0]          i_core_nonce_vld,
   output logic [CORE_NUM-1:0]          o_core_nonce_ack,
   input  logic [CORE_NUM-1:0]          i_core_done,
   output logic [DATA_WID-1:0]          ov_mining_extranounce2,
   output logic [DATA_WID-1:0]          ov_mining_nounce,
   output logic                         o_mining_nounce_vld,
   output logic                         o_mining_nounce_full,
   input  logic                         i_mining_nounce_rdy,
   output logic                         o_overflow
);

   import mining_pkg::*;

   localparam int PTR_W       = (CORE_IDX_WID == 0) ? 1 : CORE_IDX_WID;
   localparam int STALL_LIMIT = 16;

   dispatchState_t r_state;
   dispatchState_t w_nextState;

   logic                         r_enD;
   logic                         w_startEdge;
   logic                         w_abortReq;
   logic                         w_active;
   logic                         w_loadPhase;
   logic                         w_fullPhase;
   logic                         w_outVld;
   logic [CORE_NUM-1:0]          r_doneMask;
   logic [CORE_NUM-1:0]          w_doneNext;
   logic [PTR_W-1:0]             r_rrPtr;
   logic [PTR_W-1:0]             w_grantIdx;
   logic                         w_grantFound;
   logic [DATA_WID-1:0]          w_grantNonce;
   logic                         w_stallCond;
   logic                         w_drop;
   logic                         w_xfer;
   logic [4:0]                   r_stallCnt;
   logic [DATA_WID-1:0]          r_extra;
   logic [CORE_NUM*DATA_WID-1:0] w_baseAll;
   logic                         w_fifoWr;
   logic                         w_fifoRd;
   logic                         w_fifoFull;
   logic                         w_fifoEmpty;
   logic [2*DATA_WID-1:0]        w_fifoRdData;

   assign w_startEdge = i_mining_en && !r_enD;
   assign w_doneNext  = r_doneMask | i_core_done;

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_nextState;
   end

   // A start edge always restarts the job, from any state.
   always_comb begin
      w_nextState = r_state;
      if (w_startEdge) begin
         w_nextState = ST_LOAD;
      end else begin
         case (r_state)
            ST_IDLE:  w_nextState = ST_IDLE;
            ST_LOAD:  w_nextState = ST_RUN;
            ST_RUN:   if (&w_doneNext) w_nextState = ST_DRAIN;
            ST_DRAIN: if ((i_core_nonce_vld == '0) && w_fifoEmpty) w_nextState = ST_FULL;
            ST_FULL:  if (i_mining_nounce_rdy) w_nextState = ST_IDLE;
            default:  w_nextState = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_loadPhase = (r_state == ST_LOAD);
      w_fullPhase = (r_state == ST_FULL);
      w_active    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
      w_abortReq  = w_startEdge && (w_active || w_fullPhase);
      w_outVld    = w_fullPhase || !w_fifoEmpty;
   end

   // Round-robin search starting at the pointer; first valid core wins.
   always_comb begin
      w_grantFound = 1'b0;
      w_grantIdx   = '0;
      for (int k = 0; k < CORE_NUM; k++) begin
         if (!w_grantFound && i_core_nonce_vld[(int'(r_rrPtr) + k) % CORE_NUM]) begin
            w_grantFound = 1'b1;
            w_grantIdx   = PTR_W'((int'(r_rrPtr) + k) % CORE_NUM);
         end
      end
   end

   assign w_grantNonce = iv_core_nonce[(int'(w_grantIdx) % CORE_NUM)*DATA_WID +: DATA_WID];

   // A core stuck behind a full FIFO with no reader is eventually acked and dropped.
   assign w_stallCond = w_active && !w_abortReq && w_grantFound && w_fifoFull && !i_mining_nounce_rdy;
   assign w_drop      = w_stallCond && (r_stallCnt == 5'(STALL_LIMIT));
   assign w_xfer      = w_active && !w_abortReq && w_grantFound && (!w_fifoFull || w_drop);
   assign w_fifoWr    = w_xfer && !w_drop;
   assign w_fifoRd    = w_outVld && i_mining_nounce_rdy && !w_fullPhase;

   assign o_core_nonce_ack = w_xfer ? (CORE_NUM'(1) << w_grantIdx) : '0;

   always_comb begin
      w_baseAll = '0;
      for (int i = 0; i < CORE_NUM; i++) begin
         w_baseAll[i*DATA_WID +: DATA_WID] = DATA_WID'(i) << (DATA_WID - CORE_IDX_WID);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_enD              <= 1'b0;
         r_doneMask         <= '0;
         r_rrPtr            <= '0;
         r_stallCnt         <= '0;
         r_extra            <= '0;
         o_overflow         <= 1'b0;
         o_core_start       <= '0;
         o_core_abort       <= 1'b0;
         ov_core_data       <= '0;
         ov_core_target     <= '0;
         ov_core_nonce_base <= '0;
      end else begin
         r_enD        <= i_mining_en;
         o_core_start <= {CORE_NUM{w_loadPhase && !w_startEdge}};
         o_core_abort <= w_abortReq;
         if (w_drop || !w_stallCond) r_stallCnt <= '0;
         else                        r_stallCnt <= r_stallCnt + 5'd1;
         if (w_xfer) r_rrPtr <= PTR_W'((int'(w_grantIdx) + 1) % CORE_NUM);
         if (w_startEdge)              r_doneMask <= '0;
         else if (r_state == ST_RUN)   r_doneMask <= w_doneNext;
         if (w_startEdge)  o_overflow <= 1'b0;
         else if (w_drop)  o_overflow <= 1'b1;
         if (w_startEdge) begin
            ov_core_data   <= iv_mining_data;
            ov_core_target <= iv_mining_target;
            r_extra        <= iv_mining_extranounce2;
         end
         if (w_loadPhase) ov_core_nonce_base <= w_baseAll;
      end
   end

   mining_result_fifo #(
      .WIDTH (2*DATA_WID),
      .DEPTH (FIFO_DEPTH)
   ) u_resultFifo (
      .clk       (clk),
      .rst       (rst),
      .i_flush   (w_startEdge),
      .i_wr      (w_fifoWr),
      .iv_wrData ({r_extra, w_grantNonce}),
      .i_rd      (w_fifoRd),
      .ov_rdData (w_fifoRdData),
      .o_full    (w_fifoFull),
      .o_empty   (w_fifoEmpty)
   );

   // Data is forced to zero when no beat is presented.
   always_comb begin
      o_mining_nounce_vld    = w_outVld;
      o_mining_nounce_full   = w_fullPhase;
      ov_mining_nounce       = '0;
      ov_mining_extranounce2 = '0;
      if (w_fullPhase) begin
         ov_mining_nounce       = DATA_WID'(FULL_MARKER_NONCE);
         ov_mining_extranounce2 = r_extra;
      end else if (!w_fifoEmpty) begin
         {ov_mining_extranounce2, ov_mining_nounce} = w_fifoRdData;
      end
   end

endmodule
